// File: rtl/regfile_dbg_pkg.sv
// Shared types and default geometry for the register-file dump reader.
// The checksum beat is enabled by defining REGFILE_DUMP_CSUM_EN.
package regfile_dbg_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_ADDR_W   = 3;
  localparam int DEFAULT_NUM_REGS = 8;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's control, regfile read port and output stream.
// The master modport is the reader; the slave modport is the CPU/sink side.
interface regfile_dump_reader_if
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic               START;
  logic               BUSY;
  logic               DONE;
  logic [ADDR_W-1:0]  RA;
  logic [DATA_W-1:0]  RD;
  logic               DOUT_VALID;
  logic               DOUT_READY;
  logic [DATA_W-1:0]  DOUT_DATA;
  logic [ADDR_W-1:0]  DOUT_IDX;
  logic               DOUT_LAST;
  logic               CSUM_BEAT;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  START, RD, DOUT_READY,
    output BUSY, DONE, RA, DOUT_VALID, DOUT_DATA, DOUT_IDX, DOUT_LAST, CSUM_BEAT,
           dbg_state
  );

  modport slave (
    output START, RD, DOUT_READY,
    input  BUSY, DONE, RA, DOUT_VALID, DOUT_DATA, DOUT_IDX, DOUT_LAST, CSUM_BEAT,
           dbg_state
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks r0..r(NUM_REGS-1) on one regfile read port and streams each word out.
// Defining REGFILE_DUMP_CSUM_EN appends a trailing checksum beat to every dump.
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_dump_reader_if.master bus
);

  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
  localparam logic [STATE_W-1:0] S_SEND   = SEND;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam logic [STATE_W-1:0] S_CSUM   = CSUM;
`endif

  logic [STATE_W-1:0] state;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               last;
  logic               done;
  logic               fire;
`ifdef REGFILE_DUMP_CSUM_EN
  logic [DATA_W-1:0]  csum;
  logic               csum_beat;
`endif

  // Output handshake: a beat transfers on a rising edge where DOUT_VALID and
  // DOUT_READY are both high. Once VALID is raised, DATA/IDX/LAST/CSUM_BEAT
  // hold steady and VALID stays high until that transfer happens.
  assign fire = valid & bus.DOUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      data      <= '0;
      valid     <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
      csum      <= '0;
      csum_beat <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            data  <= bus.RD;
            idx   <= '0;
            ptr   <= ADDR_W'(1);
            valid <= 1'b1;
            last  <= 1'b0;
            state <= S_SEND;
`ifdef REGFILE_DUMP_CSUM_EN
            csum  <= bus.RD;
`endif
          end
        end

        S_SEND: begin
          if (fire) begin
            if (idx != LAST_IDX) begin
              data <= bus.RD;
              idx  <= ptr;
              // ptr parks on the last register so RA never leaves the dumped range.
              if (ptr != LAST_IDX) begin
                ptr <= ptr + ADDR_W'(1);
              end
`ifdef REGFILE_DUMP_CSUM_EN
              csum <= csum + bus.RD;
`else
              last <= (ptr == LAST_IDX);
`endif
            end else begin
`ifdef REGFILE_DUMP_CSUM_EN
              data      <= csum;
              idx       <= '0;
              csum_beat <= 1'b1;
              last      <= 1'b1;
              state     <= S_CSUM;
`else
              valid <= 1'b0;
              last  <= 1'b0;
              ptr   <= '0;
              done  <= 1'b1;
              state <= S_IDLE;
`endif
            end
          end
        end

`ifdef REGFILE_DUMP_CSUM_EN
        S_CSUM: begin
          if (fire) begin
            valid     <= 1'b0;
            last      <= 1'b0;
            csum_beat <= 1'b0;
            ptr       <= '0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY       = (state != S_IDLE);
  assign bus.DONE       = done;
  assign bus.RA         = ptr;
  assign bus.DOUT_VALID = valid;
  assign bus.DOUT_DATA  = data;
  assign bus.DOUT_IDX   = idx;
  assign bus.DOUT_LAST  = last;
  assign bus.dbg_state  = state;
`ifdef REGFILE_DUMP_CSUM_EN
  assign bus.CSUM_BEAT  = csum_beat;
`else
  assign bus.CSUM_BEAT  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a small register-file model on RA/RD.
// Checksum expectations are enabled when REGFILE_DUMP_CSUM_EN is defined.
module tb_regfile_dump_reader;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  regfile_dump_reader_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_dump_reader #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // register file model: one-cycle bulk preload or single write, combinational read
  logic [15:0] regs [8];
  logic        load = 1'b0;
  logic        we   = 1'b0;
  logic [2:0]  wa   = '0;
  logic [15:0] wd   = '0;

  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'(16'h1111 * i);
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign bus.RD = regs[bus.RA];

  int          tests_run = 0;
  int          fails     = 0;
  logic [15:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.DOUT_READY = 1'b0;
    tick();
    tick();
    obs = {bus.BUSY, bus.DONE, bus.DOUT_VALID, bus.DOUT_LAST, bus.CSUM_BEAT,
           bus.RA, bus.DOUT_DATA, bus.DOUT_IDX};
    tests_run++;
    if (obs !== 28'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 28'h0);
    end
    RST = 1'b0;
    preload();
  endtask

  task automatic test_full_rate();
    logic [23:0] obs;
    logic [23:0] exp;
    logic        exp_last;
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(16'h1111 * k));
    for (int k = 0; k < 8; k++) begin
`ifdef REGFILE_DUMP_CSUM_EN
      exp_last = 1'b0;
`else
      exp_last = (k == 7);
`endif
      obs = {bus.DOUT_VALID, bus.DOUT_LAST, bus.BUSY, bus.DONE, bus.CSUM_BEAT,
             bus.DOUT_IDX, bus.DOUT_DATA};
      exp = {1'b1, exp_last, 1'b1, 1'b0, 1'b0, 3'(k), exp_q.pop_front()};
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL full_rate_beat%0d: got %h expected %h", k, obs, exp);
      end
      tick();
    end
`ifdef REGFILE_DUMP_CSUM_EN
    obs = {bus.DOUT_VALID, bus.DOUT_LAST, bus.BUSY, bus.DONE, bus.CSUM_BEAT,
           bus.DOUT_IDX, bus.DOUT_DATA};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'hDDDC};
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL full_rate_csum_beat: got %h expected %h", obs, exp);
    end
    tick();
`endif
    tests_run++;
    if ({bus.DOUT_VALID, bus.DOUT_LAST, bus.BUSY, bus.DONE, bus.RA} !== 7'b0001_000) begin
      fails++;
      $display("FAIL full_rate_done_cycle: got %b expected %b",
               {bus.DOUT_VALID, bus.DOUT_LAST, bus.BUSY, bus.DONE, bus.RA}, 7'b0001_000);
    end
    tick();
    tests_run++;
    if (bus.DONE !== 1'b0) begin
      fails++;
      $display("FAIL full_rate_done_pulse: got %b expected 0", bus.DONE);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] obs;
    int n;
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    bus.DOUT_READY = 1'b0;
    for (int j = 0; j < 3; j++) begin
      obs = {bus.DOUT_VALID, bus.DOUT_IDX, bus.DOUT_DATA};
      tests_run++;
      if (obs !== {1'b1, 3'd2, 16'h2222}) begin
        fails++;
        $display("FAIL stall_hold%0d: got %h expected %h", j, obs, {1'b1, 3'd2, 16'h2222});
      end
      tick();
    end
    bus.DOUT_READY = 1'b1;
    obs = {bus.DOUT_VALID, bus.DOUT_IDX, bus.DOUT_DATA};
    tests_run++;
    if (obs !== {1'b1, 3'd2, 16'h2222}) begin
      fails++;
      $display("FAIL stall_release: got %h expected %h", obs, {1'b1, 3'd2, 16'h2222});
    end
    tick();
    obs = {bus.DOUT_VALID, bus.DOUT_IDX, bus.DOUT_DATA};
    tests_run++;
    if (obs !== {1'b1, 3'd3, 16'h3333}) begin
      fails++;
      $display("FAIL stall_next_beat: got %h expected %h", obs, {1'b1, 3'd3, 16'h3333});
    end
    n = 0;
    while (!bus.DONE && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (bus.DONE !== 1'b1) begin
      fails++;
      $display("FAIL stall_drain_timeout: done %b expected 1", bus.DONE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int beats;
    int exp_beats;
    logic [20:0] obs;
`ifdef REGFILE_DUMP_CSUM_EN
    exp_beats = 9;
`else
    exp_beats = 8;
`endif
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    cyc = 1;
    beats = 0;
    while (!bus.DONE && cyc < 30) begin
      if (bus.DOUT_VALID && bus.DOUT_READY) beats++;
      bus.START = (cyc == 4);
      tick();
      cyc++;
    end
    bus.START = 1'b0;
    tests_run++;
    if (beats !== exp_beats || bus.DONE !== 1'b1) begin
      fails++;
      $display("FAIL busy_start_ignored: beats %0d done %b expected beats %0d done 1",
               beats, bus.DONE, exp_beats);
    end
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    obs = {bus.DOUT_VALID, bus.BUSY, bus.DOUT_IDX, bus.DOUT_DATA};
    tests_run++;
    if (obs !== {1'b1, 1'b1, 3'd0, 16'h0000}) begin
      fails++;
      $display("FAIL start_in_done_cycle: got %h expected %h", obs, {1'b1, 1'b1, 3'd0, 16'h0000});
    end
    cyc = 0;
    while (!bus.DONE && cyc < 40) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (bus.DONE !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain_timeout: done %b expected 1", bus.DONE);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    logic [27:0] obs;
    logic done_seen;
    logic valid_seen;
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tests_run++;
    if ({bus.DOUT_VALID, bus.DOUT_IDX} !== {1'b1, 3'd4}) begin
      fails++;
      $display("FAIL abort_reach_beat4: got %h expected %h", {bus.DOUT_VALID, bus.DOUT_IDX}, {1'b1, 3'd4});
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    obs = {bus.BUSY, bus.DONE, bus.DOUT_VALID, bus.DOUT_LAST, bus.CSUM_BEAT,
           bus.RA, bus.DOUT_DATA, bus.DOUT_IDX};
    tests_run++;
    if (obs !== 28'h0) begin
      fails++;
      $display("FAIL abort_outputs: got %h expected %h", obs, 28'h0);
    end
    done_seen = 1'b0;
    valid_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      done_seen |= bus.DONE;
      valid_seen |= bus.DOUT_VALID;
      tick();
    end
    tests_run++;
    if ({done_seen, valid_seen} !== 2'b00) begin
      fails++;
      $display("FAIL abort_no_done: done_seen %b valid_seen %b expected 0 0", done_seen, valid_seen);
    end
  endtask

  task automatic test_live_write();
    int n;
    preload();
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    we = 1'b1;
    wa = 3'd5;
    wd = 16'hBEEF;
    tick();
    we = 1'b0;
    tick();
    tests_run++;
    if ({bus.DOUT_IDX, bus.DOUT_DATA} !== {3'd4, 16'h4444}) begin
      fails++;
      $display("FAIL live_write_beat4: got %h expected %h", {bus.DOUT_IDX, bus.DOUT_DATA}, {3'd4, 16'h4444});
    end
    tick();
    tests_run++;
    if ({bus.DOUT_VALID, bus.DOUT_IDX, bus.DOUT_DATA} !== {1'b1, 3'd5, 16'hBEEF}) begin
      fails++;
      $display("FAIL live_write_beat5: got %h expected %h",
               {bus.DOUT_VALID, bus.DOUT_IDX, bus.DOUT_DATA}, {1'b1, 3'd5, 16'hBEEF});
    end
    n = 0;
    while (!bus.DONE && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (bus.DONE !== 1'b1) begin
      fails++;
      $display("FAIL live_write_drain_timeout: done %b expected 1", bus.DONE);
    end
    tick();
  endtask

`ifdef REGFILE_DUMP_CSUM_EN
  task automatic test_checksum();
    logic [21:0] obs;
    preload();
    bus.DOUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    obs = {bus.DOUT_VALID, bus.DOUT_LAST, bus.CSUM_BEAT, bus.DOUT_IDX, bus.DOUT_DATA};
    tests_run++;
    if (obs !== {1'b1, 1'b0, 1'b0, 3'd7, 16'h7777}) begin
      fails++;
      $display("FAIL csum_reg7_not_last: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 3'd7, 16'h7777});
    end
    tick();
    bus.DOUT_READY = 1'b0;
    for (int j = 0; j < 2; j++) begin
      obs = {bus.DOUT_VALID, bus.DOUT_LAST, bus.CSUM_BEAT, bus.DOUT_IDX, bus.DOUT_DATA};
      tests_run++;
      if (obs !== {1'b1, 1'b1, 1'b1, 3'd0, 16'hDDDC}) begin
        fails++;
        $display("FAIL csum_beat_hold%0d: got %h expected %h", j, obs, {1'b1, 1'b1, 1'b1, 3'd0, 16'hDDDC});
      end
      tick();
    end
    bus.DOUT_READY = 1'b1;
    tick();
    tests_run++;
    if ({bus.DONE, bus.DOUT_VALID, bus.BUSY, bus.CSUM_BEAT} !== 4'b1000) begin
      fails++;
      $display("FAIL csum_done: got %b expected %b", {bus.DONE, bus.DOUT_VALID, bus.BUSY, bus.CSUM_BEAT}, 4'b1000);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_dump();
    test_live_write();
`ifdef REGFILE_DUMP_CSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
